ntt_loop_counter: RTL and testbench
===================================

# ntt_loop_counter

Parametrised NTT loop-index generator, the successor to the single up/down `counter` primitive. It walks every butterfly of an N = 2^LOGN point transform, stage by stage, and emits per cycle a registered stage index, the two data-memory addresses and the twiddle index. It supports ascending (Cooley-Tukey, forward) and descending (Gentleman-Sande, inverse) stage order, consumer back-pressure, and a programmable inter-stage bubble for draining the butterfly pipeline. It sits between the accelerator control FSM and the data/twiddle memories.

## Interface

- LOGN, 3, log2 of transform size; legal range 2..12.
- SW, 2, stage index width; must satisfy 2^SW >= LOGN.
- GAP, 0, idle cycles inserted between consecutive stages; legal range 0..15.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a transform; sampled only in IDLE.
- down  in  1  stage order: 0 ascending 0..LOGN-1, 1 descending LOGN-1..0; latched at start.
- stall  in  1  consumer back-pressure; holds the current butterfly.
- valid  out  1  outputs carry a butterfly.
- stage  out  SW  current stage s.
- addr_a  out  LOGN  first operand address.
- addr_b  out  LOGN  second operand address.
- tw_idx  out  LOGN-1  twiddle index.
- stage_last  out  1  current butterfly is the last of its stage.
- busy  out  1  high in RUN and GAP.
- done  out  1  one-cycle pulse after the final butterfly is accepted.

## Operation

- FSM states: IDLE, RUN, GAP, DONE. Reset forces IDLE. In reset, all outputs are 0 and the internal butterfly counter i, stage, gap counter and latched mode are cleared.
- IDLE -> RUN on start=1. Stage loads 0 (down=0) or LOGN-1 (down=1), and i loads 0.
- Acceptance: a butterfly is consumed on any rising edge where valid=1 and stall=0. With stall=1, every output and all state hold unchanged.
- Per-butterfly index math, with half = 2^s and i in 0..N/2-1:
  - j = i & (half-1); g = i >> s.
  - addr_a = (g << (s+1)) | j.
  - addr_b = addr_a | half.
  - tw_idx = j << (LOGN-1-s).
  - All values are unsigned, truncated to their port width.
- In RUN, on acceptance with i < N/2-1: i increments by 1.
- In RUN, on acceptance with i = N/2-1 (stage_last=1):
  - Final stage (s = LOGN-1 ascending, s = 0 descending) -> DONE.
  - Otherwise, with GAP>0 -> GAP; with GAP=0 -> stay in RUN.
  - In both non-final cases, i resets to 0 and stage steps by +1 (ascending) or -1 (descending).
- GAP: valid=0 and busy=1 for exactly GAP cycles; stall is ignored. Then return to RUN.
- DONE: done=1, valid=0, busy=0 for one cycle, then unconditionally IDLE. A start pulse during DONE is ignored.
- start in RUN, GAP or DONE is ignored. down is sampled only on the start edge; later changes have no effect on the run in progress.
- stage_last = valid & (i == N/2-1).
- Reset asserted mid-run aborts immediately: no done pulse, and outputs go to 0 asynchronously.

## Timing

- All outputs are registered. There is no combinational path from any input to any output.
- With start high at edge 0, the first butterfly appears (valid=1) after edge 0, in cycle 1.
- With stall=0 throughout, a run lasts LOGN·N/2 valid cycles plus (LOGN-1)·GAP bubble cycles.
- done is high in the cycle after the final accepted butterfly. The earliest next start is accepted at the following edge, when the FSM is back in IDLE.
- Throughput is one butterfly per cycle; there are no bubbles inside a stage.

## Test plan

- **Ascending, no gaps:** LOGN=3, GAP=0, down=0, start at cycle 0, stall=0 -> valid in cycles 1-12, then done in cycle 13.
  - Stage 0 (a,b): (0,1) (2,3) (4,5) (6,7), all tw=0.
  - Stage 1 (a,b,tw): (0,2,0) (1,3,2) (4,6,0) (5,7,2).
  - Stage 2 (a,b,tw): (0,4,0) (1,5,1) (2,6,2) (3,7,3).
  - stage_last is high in cycles 4, 8 and 12.
- **Descending:** down=1, otherwise as above -> identical per-stage tuples, emitted in stage order 2, 1, 0.
  - First butterfly: stage=2, a=0, b=4, tw=0.
  - done in cycle 13.
- **Inter-stage gap:** GAP=2 -> valid=0 with busy=1 in cycles 5-6 and 11-12; done in cycle 17.
- **Back-pressure:** stall=1 in cycles 3-5 -> outputs frozen at the stage 0, i=2 butterfly (a=4, b=5) for cycles 3-6; done slips to cycle 16.
- **Reset mid-run:** rst pulse in cycle 7 -> all outputs 0 immediately, no done pulse.
  - start in cycle 9 produces a fresh run from stage 0, i=0.
- **Ignored starts:** start held high throughout the run and in the DONE cycle -> sequence identical to the first scenario, with a single done pulse.
  - The next run begins only with the IDLE-cycle start: edge at cycle 14, first butterfly in cycle 15.

Source files
------------

// File: rtl/ntt_loop_counter_if.sv
// Handshake and index bus between the NTT control FSM (master) and the
// loop-index generator (slave).
interface ntt_loop_counter_if #(
    parameter int LOGN = 3,
    parameter int SW   = 2
);
    logic            start;
    logic            down;
    logic            stall;
    logic            valid;
    logic [SW-1:0]   stage;
    logic [LOGN-1:0] addr_a;
    logic [LOGN-1:0] addr_b;
    logic [LOGN-2:0] tw_idx;
    logic            stage_last;
    logic            busy;
    logic            done;

    modport master (
        output start, down, stall,
        input  valid, stage, addr_a, addr_b, tw_idx, stage_last, busy, done
    );

    modport slave (
        input  start, down, stall,
        output valid, stage, addr_a, addr_b, tw_idx, stage_last, busy, done
    );
endinterface

// File: rtl/ntt_loop_counter.sv
// NTT butterfly walker: steps through every butterfly of a 2^LOGN point
// transform stage by stage and emits registered addresses and twiddle index.
module ntt_loop_counter #(
    parameter int LOGN = 3,
    parameter int SW   = 2,
    parameter int GAP  = 0
) (
    input logic clk,
    input logic rst,
    ntt_loop_counter_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_GAP, S_DONE} state_t;

    localparam logic [LOGN-2:0] ILAST = '1;
    localparam logic [SW-1:0]   SMAX  = SW'(LOGN - 1);
    localparam logic [3:0]      GAPV  = 4'(GAP);

    state_t          state, state_n;
    logic [LOGN-2:0] i, i_n;
    logic [SW-1:0]   s, s_n;
    logic [3:0]      gcnt, gcnt_n;
    logic            dn, dn_n;

    logic            valid_n, busy_n;
    logic [LOGN-1:0] iw, mask, jv, gv, av, bv;
    logic [LOGN-2:0] tv;

    logic            valid_q, busy_q, done_q, last_q;
    logic [SW-1:0]   stage_q;
    logic [LOGN-1:0] addr_a_q, addr_b_q;
    logic [LOGN-2:0] tw_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            i     <= '0;
            s     <= '0;
            gcnt  <= '0;
            dn    <= 1'b0;
        end else begin
            state <= state_n;
            i     <= i_n;
            s     <= s_n;
            gcnt  <= gcnt_n;
            dn    <= dn_n;
        end
    end

    // A stalled butterfly leaves every next-value equal to the current one,
    // so the output registers below simply reload what they already hold.
    always_comb begin
        state_n = state;
        i_n     = i;
        s_n     = s;
        gcnt_n  = gcnt;
        dn_n    = dn;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    state_n = S_RUN;
                    i_n     = '0;
                    dn_n    = bus.down;
                    s_n     = bus.down ? SMAX : '0;
                end
            end
            S_RUN: begin
                if (!bus.stall) begin
                    if (i != ILAST) begin
                        i_n = i + 1'b1;
                    end else if (dn ? (s == '0) : (s == SMAX)) begin
                        state_n = S_DONE;
                    end else begin
                        i_n = '0;
                        s_n = dn ? (s - 1'b1) : (s + 1'b1);
                        if (GAP > 0) begin
                            state_n = S_GAP;
                            gcnt_n  = GAPV - 4'd1;
                        end
                    end
                end
            end
            S_GAP: begin
                if (gcnt == '0) state_n = S_RUN;
                else            gcnt_n  = gcnt - 4'd1;
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Index math on the upcoming (i, s) so every output can be registered.
    always_comb begin
        valid_n = (state_n == S_RUN);
        busy_n  = (state_n == S_RUN) || (state_n == S_GAP);
        iw      = {1'b0, i_n};
        mask    = (LOGN'(1) << s_n) - LOGN'(1);
        jv      = iw & mask;
        gv      = iw >> s_n;
        av      = (gv << (int'(s_n) + 1)) | jv;
        bv      = av | (LOGN'(1) << s_n);
        tv      = (LOGN-1)'(jv << (LOGN - 1 - int'(s_n)));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            last_q   <= 1'b0;
            stage_q  <= '0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            tw_q     <= '0;
        end else begin
            valid_q  <= valid_n;
            busy_q   <= busy_n;
            done_q   <= (state_n == S_DONE);
            last_q   <= valid_n && (i_n == ILAST);
            stage_q  <= busy_n  ? s_n : '0;
            addr_a_q <= valid_n ? av  : '0;
            addr_b_q <= valid_n ? bv  : '0;
            tw_q     <= valid_n ? tv  : '0;
        end
    end

    assign bus.valid      = valid_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.stage_last = last_q;
    assign bus.stage      = stage_q;
    assign bus.addr_a     = addr_a_q;
    assign bus.addr_b     = addr_b_q;
    assign bus.tw_idx     = tw_q;
endmodule

// File: tb/tb_ntt_loop_counter.sv
// Bench for ntt_loop_counter: two instances (GAP=0 and GAP=2) driven with
// directed and random stall patterns against a per-stage butterfly list model.
module tb_ntt_loop_counter;
    localparam int LOGN = 3;
    localparam int SW   = 2;
    localparam int N    = 1 << LOGN;
    localparam int GAP1 = 2;
    localparam int VW   = 4 + SW + 2 * LOGN + LOGN - 1;

    typedef struct {
        bit v;
        int stage;
        int a;
        int b;
        int tw;
        bit last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_s [2];
    logic down_s  [2];
    logic stall_s [2];
    logic valid_o [2];
    logic busy_o  [2];
    logic done_o  [2];
    logic last_o  [2];
    logic [SW-1:0]   stage_o [2];
    logic [LOGN-1:0] a_o [2];
    logic [LOGN-1:0] b_o [2];
    logic [LOGN-2:0] tw_o [2];

    int vectors = 0;
    int miscompares = 0;

    ntt_loop_counter_if #(.LOGN(LOGN), .SW(SW)) bus0 ();
    ntt_loop_counter_if #(.LOGN(LOGN), .SW(SW)) bus1 ();

    assign bus0.start = start_s[0];
    assign bus0.down  = down_s[0];
    assign bus0.stall = stall_s[0];
    assign bus1.start = start_s[1];
    assign bus1.down  = down_s[1];
    assign bus1.stall = stall_s[1];

    assign valid_o[0] = bus0.valid;
    assign busy_o[0]  = bus0.busy;
    assign done_o[0]  = bus0.done;
    assign last_o[0]  = bus0.stage_last;
    assign stage_o[0] = bus0.stage;
    assign a_o[0]     = bus0.addr_a;
    assign b_o[0]     = bus0.addr_b;
    assign tw_o[0]    = bus0.tw_idx;
    assign valid_o[1] = bus1.valid;
    assign busy_o[1]  = bus1.busy;
    assign done_o[1]  = bus1.done;
    assign last_o[1]  = bus1.stage_last;
    assign stage_o[1] = bus1.stage;
    assign a_o[1]     = bus1.addr_a;
    assign b_o[1]     = bus1.addr_b;
    assign tw_o[1]    = bus1.tw_idx;

    ntt_loop_counter #(.LOGN(LOGN), .SW(SW), .GAP(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    ntt_loop_counter #(.LOGN(LOGN), .SW(SW), .GAP(GAP1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    initial forever #5 clk = ~clk;

    function automatic int gap_of(input int k);
        return (k == 0) ? 0 : GAP1;
    endfunction

    function automatic logic [VW-1:0] got_vec(input int k);
        return {valid_o[k], busy_o[k], done_o[k], last_o[k],
                stage_o[k], a_o[k], b_o[k], tw_o[k]};
    endfunction

    function automatic logic [VW-1:0] exp_vec(input exp_t e);
        return {1'b1, 1'b1, 1'b0, e.last, SW'(e.stage),
                LOGN'(e.a), LOGN'(e.b), (LOGN-1)'(e.tw)};
    endfunction

    // Runs one transform on instance k; returns early at abort_cyc, or after
    // the idle cycle that follows the done pulse.
    task automatic run_check(input int k, input bit dn, input int pct,
                             input int st_lo, input int st_hi,
                             input bit hold, input int abort_cyc);
        exp_t q[$];
        exp_t e;
        int   cyc, nst, nent, budget, s, half, cnt;
        bit   st;
        for (int t = 0; t < LOGN; t++) begin
            s    = dn ? (LOGN - 1 - t) : t;
            half = 1 << s;
            cnt  = 0;
            for (int g = 0; g < N / (2 * half); g++) begin
                for (int j = 0; j < half; j++) begin
                    e.v     = 1'b1;
                    e.stage = s;
                    e.a     = g * 2 * half + j;
                    e.b     = e.a + half;
                    e.tw    = j * (N / (2 * half));
                    e.last  = (cnt == N / 2 - 1);
                    cnt++;
                    q.push_back(e);
                end
            end
            if (t < LOGN - 1) begin
                for (int z = 0; z < gap_of(k); z++) begin
                    e.v = 1'b0;
                    q.push_back(e);
                end
            end
        end
        nent = q.size();
        nst  = 0;
        @(negedge clk);
        down_s[k]  = dn;
        start_s[k] = 1'b1;
        @(negedge clk);
        cyc        = 1;
        start_s[k] = hold;
        down_s[k]  = 1'($urandom_range(1));
        budget     = 1000;
        while (q.size() > 0 && budget > 0) begin
            e = q[0];
            vectors++;
            if (e.v) begin
                if (got_vec(k) !== exp_vec(e)) begin
                    miscompares++;
                    $display("[TB] FAIL butterfly k=%0d cyc=%0d got=%h exp=%h",
                             k, cyc, got_vec(k), exp_vec(e));
                end
            end else if (got_vec(k)[VW-1 -: 3] !== 3'b010) begin
                miscompares++;
                $display("[TB] FAIL gap_bubble k=%0d cyc=%0d got=%b exp=010",
                         k, cyc, got_vec(k)[VW-1 -: 3]);
            end
            if (cyc == abort_cyc) return;
            st = (cyc >= st_lo && cyc <= st_hi) || (int'($urandom_range(99)) < pct);
            stall_s[k] = st;
            if (e.v && st) nst++;
            @(negedge clk);
            cyc++;
            budget--;
            if (!(e.v && st)) void'(q.pop_front());
        end
        stall_s[k] = 1'b0;
        if (budget == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL run_timeout k=%0d got=%0d left exp=0", k, q.size());
        end
        vectors++;
        if (got_vec(k)[VW-1 -: 4] !== 4'b0010) begin
            miscompares++;
            $display("[TB] FAIL done_pulse k=%0d cyc=%0d got=%b exp=0010",
                     k, cyc, got_vec(k)[VW-1 -: 4]);
        end
        vectors++;
        if (cyc != nent + nst + 1) begin
            miscompares++;
            $display("[TB] FAIL done_cycle k=%0d got=%0d exp=%0d", k, cyc, nent + nst + 1);
        end
        @(negedge clk);
        vectors++;
        if (got_vec(k)[VW-1 -: 4] !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL idle_after_done k=%0d got=%b exp=0000",
                     k, got_vec(k)[VW-1 -: 4]);
        end
    endtask

    task automatic test_reset;
        for (int k = 0; k < 2; k++) begin
            start_s[k] = 1'b0;
            down_s[k]  = 1'b0;
            stall_s[k] = 1'b0;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (got_vec(k) !== '0) begin
                miscompares++;
                $display("[TB] FAIL reset_state k=%0d got=%h exp=0", k, got_vec(k));
            end
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_ascending;
        run_check(0, 1'b0, 0, 0, -1, 1'b0, 0);
    endtask

    task automatic test_descending;
        run_check(0, 1'b1, 0, 0, -1, 1'b0, 0);
    endtask

    task automatic test_gap;
        run_check(1, 1'b0, 0, 0, -1, 1'b0, 0);
        run_check(1, 1'b1, 0, 0, -1, 1'b0, 0);
    endtask

    task automatic test_backpressure;
        run_check(0, 1'b0, 0, 3, 5, 1'b0, 0);
        run_check(1, 1'b1, 0, 3, 5, 1'b0, 0);
    endtask

    task automatic test_reset_midrun;
        run_check(0, 1'b0, 0, 0, -1, 1'b0, 7);
        #1 rst = 1'b1;
        #1;
        vectors++;
        if (got_vec(0) !== '0) begin
            miscompares++;
            $display("[TB] FAIL async_reset got=%h exp=0", got_vec(0));
        end
        #1 rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (got_vec(0)[VW-1 -: 4] !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL no_done_after_abort got=%b exp=0000", got_vec(0)[VW-1 -: 4]);
        end
        run_check(0, 1'b0, 0, 0, -1, 1'b0, 0);
    endtask

    task automatic test_ignored_starts;
        int budget;
        run_check(0, 1'b0, 0, 0, -1, 1'b1, 0);
        down_s[0] = 1'b0;
        @(negedge clk);
        vectors++;
        if (got_vec(0) !== {4'b1100, SW'(0), LOGN'(0), LOGN'(1), (LOGN-1)'(0)}) begin
            miscompares++;
            $display("[TB] FAIL restart_from_idle got=%h exp=%h", got_vec(0),
                     {4'b1100, SW'(0), LOGN'(0), LOGN'(1), (LOGN-1)'(0)});
        end
        start_s[0] = 1'b0;
        budget = 200;
        while (done_o[0] !== 1'b1 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        vectors++;
        if (budget == 0) begin
            miscompares++;
            $display("[TB] FAIL drain_timeout got=%0d exp=done", budget);
        end
        @(negedge clk);
    endtask

    task automatic test_random;
        for (int r = 0; r < 12; r++) begin
            run_check(int'($urandom_range(1)), 1'($urandom_range(1)),
                      int'($urandom_range(50)), 0, -1, 1'b0, 0);
        end
    endtask

    initial begin
        test_reset;
        test_ascending;
        test_descending;
        test_gap;
        test_backpressure;
        test_reset_midrun;
        test_ignored_starts;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
